// File: rtl/div_sched_pkg.sv
// Shared definitions for the divider-array job controller: lane count,
// sequencer states and the lane slicing helper.
package div_sched_pkg;

    localparam int LANES = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Lane i occupies bits [lane_lo(i)+width-1 : lane_lo(i)] of a packed lane vector.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/div_sched_sat.sv
// Per-lane saturation used in place of a divide-by-zero: positive dividends
// go to the most positive quotient, negative to the most negative, zero stays zero.
module div_sched_sat
    import div_sched_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic [LANES*WIDTH-1:0] dividends,
    output logic [LANES*WIDTH-1:0] saturated
);

    localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        saturated = '0;
        for (int i = 0; i < LANES; i++) begin
            if (dividends[lane_lo(i, WIDTH) + WIDTH - 1]) begin
                saturated[lane_lo(i, WIDTH) +: WIDTH] = NEG_MAX;
            end else if (|dividends[lane_lo(i, WIDTH) +: WIDTH]) begin
                saturated[lane_lo(i, WIDTH) +: WIDTH] = POS_MAX;
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Job controller for the 16-lane divider array: one-entry input buffer, launch/wait
// sequencer with timeout, and a valid/ready result register. Zero-divisor guard: DIV_SCHED_ZERO_GUARD_EN.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int WIDTH   = 14,
    parameter int FBITS   = 7,
    parameter int BWIDTH  = 12,
    parameter int TIMEOUT = 63
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   in_sums,
    input  logic [BWIDTH-1:0]        in_divisor,
    output logic                     div_start,
    output logic [LANES*WIDTH-1:0]   div_dividends,
    output logic [BWIDTH-1:0]        div_divisor,
    input  logic                     div_done,
    input  logic [LANES*WIDTH-1:0]   div_results,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     err_timeout,
    output logic                     err_div_zero
);

    localparam int DW = LANES * WIDTH;
    localparam int CW = $clog2(TIMEOUT + 1);

    if (FBITS >= WIDTH || BWIDTH < 1 || TIMEOUT < 3) begin : g_bad_cfg
        $error("div_sched: inconsistent parameters");
    end

    state_t              state;
    state_t              state_nxt;

    logic                buf_full;
    logic [DW-1:0]       buf_sums;
    logic [BWIDTH-1:0]   buf_divisor;

    logic [DW-1:0]       op_dividends;
    logic [BWIDTH-1:0]   op_divisor;

    logic [CW-1:0]       tmo_cnt;
    logic                out_full;
    logic [DW-1:0]       out_reg;
    logic                err_tmo_q;

    logic                take_in;
    logic                out_free;
    logic                zero_job;
    logic                launch_go;
    logic                capture;
    logic                zero_capture;
    logic                abort;
    logic [DW-1:0]       capture_data;

    assign take_in  = in_valid && !buf_full;
    assign in_ready = !buf_full;
    assign out_free = !out_full || out_ready;

`ifdef DIV_SCHED_ZERO_GUARD_EN
    logic [DW-1:0] sat_data;
    logic          err_zero_q;

    assign zero_job = (op_divisor == '0);

    div_sched_sat #(
        .WIDTH(WIDTH)
    ) u_sat (
        .dividends(op_dividends),
        .saturated(sat_data)
    );

    assign capture_data = zero_capture ? sat_data : div_results;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_zero_q <= 1'b0;
        end else if (zero_capture) begin
            err_zero_q <= 1'b1;
        end
    end

    assign err_div_zero = err_zero_q;
`else
    assign zero_job     = 1'b0;
    assign capture_data = div_results;
    assign err_div_zero = 1'b0;
`endif

    // A job only leaves IDLE when its result is guaranteed a free output slot.
    always_comb begin
        state_nxt    = state;
        div_start    = 1'b0;
        launch_go    = 1'b0;
        capture      = 1'b0;
        zero_capture = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (buf_full && out_free) begin
                    launch_go = 1'b1;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                if (zero_job) begin
                    zero_capture = 1'b1;
                    state_nxt    = IDLE;
                end else begin
                    div_start = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (div_done) begin
                    capture   = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_cnt == CW'(TIMEOUT - 1)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full    <= 1'b0;
            buf_sums    <= '0;
            buf_divisor <= '0;
        end else if (take_in) begin
            buf_full    <= 1'b1;
            buf_sums    <= in_sums;
            buf_divisor <= in_divisor;
        end else if (launch_go) begin
            buf_full    <= 1'b0;
        end
    end

    // Operands are loaded on entry to LAUNCH so they are already stable alongside div_start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_dividends <= '0;
            op_divisor   <= '0;
        end else if (launch_go) begin
            op_dividends <= buf_sums;
            op_divisor   <= buf_divisor;
        end
    end

    assign div_dividends = op_dividends;
    assign div_divisor   = op_divisor;

    // tmo_cnt holds the number of cycles elapsed since the div_start cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == LAUNCH) begin
            tmo_cnt <= CW'(1);
        end else if (state == WAIT) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_full <= 1'b0;
            out_reg  <= '0;
        end else if (capture || zero_capture) begin
            out_full <= 1'b1;
            out_reg  <= capture_data;
        end else if (out_ready) begin
            out_full <= 1'b0;
        end
    end

    assign out_valid = out_full;
    assign out_data  = out_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_tmo_q <= 1'b0;
        end else if (abort) begin
            err_tmo_q <= 1'b1;
        end
    end

    assign err_timeout = err_tmo_q;

endmodule

// File: tb/tb_div_sched.sv
// Self-checking bench for div_sched: directed scenarios plus randomized jobs
// against a queue of quotients computed with plain integer division.
module tb_div_sched;

    localparam int LN     = 16;
    localparam int W      = 14;
    localparam int BW     = 12;
    localparam int TMO    = 63;
    localparam int DW     = LN * W;
    localparam int NJOBS  = 40;
    localparam logic [DW-1:0] GARBAGE = {LN{14'h2AAA}};

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_sums;
    logic [BW-1:0] in_divisor;
    logic          div_start;
    logic [DW-1:0] div_dividends;
    logic [BW-1:0] div_divisor;
    logic          div_done;
    logic [DW-1:0] div_results;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          err_timeout;
    logic          err_div_zero;

    int vec_count  = 0;
    int miss_count = 0;

    logic [DW-1:0] sb_q[$];

    int            lat  = 10;
    bit            hang = 1'b0;
    int            rem;
    logic          busy;
    logic [DW-1:0] res;

    div_sched #(
        .WIDTH(W), .FBITS(7), .BWIDTH(BW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sums(in_sums), .in_divisor(in_divisor),
        .div_start(div_start), .div_dividends(div_dividends), .div_divisor(div_divisor),
        .div_done(div_done), .div_results(div_results),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err_timeout(err_timeout), .err_div_zero(err_div_zero)
    );

    always #5 clk = ~clk;

    // Expected quotients: truncating signed division per lane, or saturation for a zero divisor.
    function automatic logic [DW-1:0] ref_job(input logic [DW-1:0] s, input logic [BW-1:0] d);
        logic [DW-1:0] r;
        int a;
        int q;
        r = '0;
        for (int i = 0; i < LN; i++) begin
            a = int'($signed(s[i*W +: W]));
            if (d == '0) begin
`ifdef DIV_SCHED_ZERO_GUARD_EN
                q = (a > 0) ? (2**(W-1) - 1) : ((a < 0) ? -(2**(W-1)) : 0);
`else
                q = 0;
`endif
            end else begin
                q = a / int'(d);
            end
            r[i*W +: W] = q[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] fill_lanes(input logic [W-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < LN; i++) r[i*W +: W] = v;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_count++;
        if (got !== exp) begin
            miss_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [DW-1:0] s, input logic [BW-1:0] d,
                                 input logic rdy);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_sums    = s;
        in_divisor = d;
        out_ready  = rdy;
        @(negedge clk);
    endtask

    task automatic wait_start(input string tag, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (div_start) ok = 1'b1;
        end
        checkOutput(tag, DW'(ok), DW'(1));
    endtask

    task automatic wait_valid(input string tag, input int budget, input logic rdy);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            applyStimulus(1'b0, '0, '0, rdy);
            if (out_valid) ok = 1'b1;
        end
        checkOutput(tag, DW'(ok), DW'(1));
    endtask

    task automatic run_basic(input string tag);
        logic [DW-1:0] s;
        bit ok;
        s   = fill_lanes(W'(1536));
        lat = 10;
        applyStimulus(1'b1, s, BW'(3), 1'b1);
        checkOutput({tag, "_in_ready"}, DW'(in_ready), DW'(1));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput({tag, "_no_start_T"}, DW'(div_start), DW'(0));
        checkOutput({tag, "_buf_full"}, DW'(in_ready), DW'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput({tag, "_start_T1"}, DW'(div_start), DW'(1));
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            if (div_done) ok = 1'b1;
        end
        checkOutput({tag, "_done_seen"}, DW'(ok), DW'(1));
        checkOutput({tag, "_valid_at_D"}, DW'(out_valid), DW'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput({tag, "_valid_D1"}, DW'(out_valid), DW'(1));
        checkOutput({tag, "_data"}, out_data, fill_lanes(W'(512)));
        applyStimulus(1'b0, '0, '0, 1'b1);
    endtask

    // Divider array stand-in: latency set by 'lat', never finishes while 'hang' is set.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_done <= 1'b0;
            busy     <= 1'b0;
            rem      <= 0;
            res      <= '0;
        end else if (div_start) begin
            div_done <= 1'b0;
            busy     <= 1'b1;
            rem      <= lat;
            res      <= ref_job(div_dividends, div_divisor);
        end else if (busy && !hang) begin
            if (rem <= 1) begin
                div_done <= 1'b1;
                busy     <= 1'b0;
            end else begin
                rem <= rem - 1;
            end
        end
    end

    assign div_results = div_done ? res : GARBAGE;

    // Scoreboard: expected results enter on input handshake, leave on output handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (in_valid && in_ready) sb_q.push_back(ref_job(in_sums, in_divisor));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checkOutput("sb_unexpected_out", out_data, '0);
                    checkOutput("sb_unexpected_valid", DW'(out_valid), DW'(0));
                end else begin
                    checkOutput("sb_out_data", out_data, sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [DW-1:0] s1, s2, zs, exp1;
        int  starts, bad_hold, acc, offered;
        bit  took;

        rst = 1'b1; in_valid = 1'b0; in_sums = '0; in_divisor = '0; out_ready = 1'b0;
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_in_ready", DW'(in_ready), DW'(1));
        checkOutput("rst_out_valid", DW'(out_valid), DW'(0));
        checkOutput("rst_div_start", DW'(div_start), DW'(0));
        checkOutput("rst_out_data", out_data, '0);
        checkOutput("rst_err_timeout", DW'(err_timeout), DW'(0));
        checkOutput("rst_err_div_zero", DW'(err_div_zero), DW'(0));
        @(posedge clk); @(posedge clk); #1 rst = 1'b1;

        $display("[TB] basic job");
        run_basic("basic");

        $display("[TB] backpressure");
        for (int i = 0; i < LN; i++) begin
            s1[i*W +: W] = W'(i * 97 - 700);
            s2[i*W +: W] = W'(1000 - i * 131);
        end
        exp1 = ref_job(s1, BW'(7));
        applyStimulus(1'b1, s1, BW'(7), 1'b0);
        wait_valid("bp_first_valid", 60, 1'b0);
        checkOutput("bp_first_data", out_data, exp1);
        applyStimulus(1'b1, s2, BW'(9), 1'b0);
        starts = 0; bad_hold = 0;
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0);
            if (div_start) starts++;
            if (out_data !== exp1 || !out_valid || in_ready) bad_hold++;
        end
        checkOutput("bp_start_withheld", DW'(starts), DW'(0));
        checkOutput("bp_hold_cycles", DW'(bad_hold), DW'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("bp_no_start_on_release", DW'(div_start), DW'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("bp_second_start", DW'(div_start), DW'(1));
        wait_valid("bp_second_valid", 60, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);

        $display("[TB] timeout");
        hang = 1'b1;
        applyStimulus(1'b1, s1, BW'(5), 1'b1);
        wait_start("tmo_start", 10);
        repeat (TMO - 1) applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("tmo_err_early", DW'(err_timeout), DW'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("tmo_err_set", DW'(err_timeout), DW'(1));
        checkOutput("tmo_out_valid", DW'(out_valid), DW'(0));
        sb_q.delete();
        hang = 1'b0;
        run_basic("tmo_next");

        $display("[TB] zero divisor");
        for (int i = 0; i < LN; i++)
            zs[i*W +: W] = (i % 3 == 0) ? W'(640) : ((i % 3 == 1) ? W'(-640) : '0);
        applyStimulus(1'b1, zs, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
`ifdef DIV_SCHED_ZERO_GUARD_EN
        checkOutput("zero_no_start", DW'(div_start), DW'(0));
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("zero_valid", DW'(out_valid), DW'(1));
        checkOutput("zero_sat_lane0", DW'(out_data[W-1:0]), DW'(8191));
        checkOutput("zero_sat_lane1", DW'(out_data[2*W-1:W]), DW'(14'h2000));
        checkOutput("zero_sat_lane2", DW'(out_data[3*W-1:2*W]), DW'(0));
        checkOutput("zero_err", DW'(err_div_zero), DW'(1));
`else
        checkOutput("zero_start_issued", DW'(div_start), DW'(1));
        wait_valid("zero_valid", 40, 1'b1);
        checkOutput("zero_err_clear", DW'(err_div_zero), DW'(0));
`endif
        applyStimulus(1'b0, '0, '0, 1'b1);

        $display("[TB] reset mid-wait");
        lat = 30;
        applyStimulus(1'b1, s1, BW'(3), 1'b1);
        wait_start("rstw_start", 10);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, s2, BW'(6), 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("rstw_buf_full", DW'(in_ready), DW'(0));
        rst = 1'b0;
        #1;
        checkOutput("rstw_in_ready", DW'(in_ready), DW'(1));
        checkOutput("rstw_out_valid", DW'(out_valid), DW'(0));
        checkOutput("rstw_div_start", DW'(div_start), DW'(0));
        checkOutput("rstw_dividends", div_dividends, '0);
        checkOutput("rstw_divisor", DW'(div_divisor), DW'(0));
        checkOutput("rstw_out_data", out_data, '0);
        checkOutput("rstw_err_timeout", DW'(err_timeout), DW'(0));
        checkOutput("rstw_err_div_zero", DW'(err_div_zero), DW'(0));
        sb_q.delete();
        applyStimulus(1'b0, '0, '0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        run_basic("after_rst");

        $display("[TB] random jobs");
        acc = 0; offered = 0; took = 1'b0;
        for (int c = 0; c < 6000 && !(acc == NJOBS && sb_q.size() == 0); c++) begin
            @(posedge clk);
            #1;
            if (took) begin
                in_valid = 1'b0;
                acc++;
            end
            if (!in_valid && offered < NJOBS && $urandom_range(0, 2) != 0) begin
                for (int i = 0; i < LN; i++) in_sums[i*W +: W] = W'($urandom_range(0, 2**W - 1));
                in_divisor = ($urandom_range(0, 7) == 0) ? '0 : BW'($urandom_range(1, 2**BW - 1));
                in_valid   = 1'b1;
                offered++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            lat       = $urandom_range(1, 20);
            @(negedge clk);
            took = in_valid && in_ready;
        end
        in_valid = 1'b0;
        checkOutput("rand_jobs_accepted", DW'(acc), DW'(NJOBS));
        checkOutput("rand_drained", DW'(sb_q.size()), DW'(0));
        checkOutput("rand_no_timeout", DW'(err_timeout), DW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/div_sched.md
# div_sched

Job controller for the 16-lane fixed-point divider array used for average pooling and SE squeeze.
- Accepts one job per handshake: 16 packed signed dividends plus one shared divisor.
- Buffers one pending job, pulses the array's start, waits for its done and captures the 16 quotients into an output register with a valid/ready handshake.
- Sits between the channel-sum accumulator and the SE/FC stage; owns all sequencing of the divider array.

## Interface
- WIDTH, 14, dividend/quotient width (Q integer.FBITS)
- FBITS, 7, fractional bits of dividend and quotient
- BWIDTH, 12, divisor width (integer, positive)
- TIMEOUT, 63, max cycles in WAIT before abort (≥ divider latency + 2)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  job offered
- in_ready  out  1  input buffer empty
- in_sums  in  16*WIDTH  packed signed dividends, lane i at [WIDTH*(i+1)-1:WIDTH*i]
- in_divisor  in  BWIDTH  shared divisor
- div_start  out  1  one-cycle start pulse to array
- div_dividends  out  16*WIDTH  operands, stable from LAUNCH until done
- div_divisor  out  BWIDTH  divisor, stable likewise
- div_done  in  1  array-wide done (AND of lanes), level
- div_results  in  16*WIDTH  array quotients, valid while div_done=1
- out_valid  out  1  result register full
- out_ready  in  1  consumer accepts
- out_data  out  16*WIDTH  captured quotients
- err_timeout  out  1  sticky, set on WAIT abort
- err_div_zero  out  1  sticky, zero divisor seen (macro-dependent)

## Operation
- Input buffer: one entry. Capture on in_valid & in_ready; in_ready = !buf_full. Buffer frees on the LAUNCH cycle.
- FSM states: IDLE, LAUNCH, WAIT.
  - IDLE → LAUNCH when buf_full and the output register is free or being freed this cycle (out_valid=0 or out_ready=1).
  - LAUNCH: move buffer into operand registers, div_start=1 for exactly one cycle, clear the timeout counter, go to WAIT.
  - WAIT: if div_done=1, capture div_results into out_data, set out_valid, go to IDLE.
  - WAIT abort: if the counter reaches TIMEOUT, set err_timeout, drop the job (out_valid unchanged), go to IDLE.
  - div_done is ignored in IDLE and LAUNCH.
- Output register: out_valid clears on out_ready. A capture and a consume in the same cycle is impossible by the launch rule.
- Operand registers hold the value from LAUNCH until the next LAUNCH.
- Error flags clear only on reset.
- No arithmetic on the datapath except the zero guard. Quotients pass through bit-exact.

## Timing
- Reset values: in_ready=1 after reset, out_valid=0, div_start=0, all data registers 0, err_*=0, state IDLE.
- Job accepted at edge T: LAUNCH (div_start=1) in cycle T+1, WAIT from T+2.
- div_done first high in cycle D: out_valid=1 from D+1.
- Back-to-back throughput: one job per (divider latency + 2) cycles, provided the consumer keeps out_ready=1.
- Second job may be accepted during WAIT; it launches the cycle after IDLE is re-entered.
- Reset asserted mid-WAIT: everything returns to reset values immediately. The divider array is reset by the same rst.

## Configuration
- DIV_SCHED_ZERO_GUARD_EN defined:
  - LAUNCH with divisor=0 issues no div_start.
  - Instead, out_data is loaded directly in that cycle with per-lane saturation: dividend >0 → 2^(WIDTH-1)-1, <0 → -2^(WIDTH-1), =0 → 0.
  - out_valid=1 next cycle, err_div_zero set, FSM → IDLE.
- Undefined: zero divisors go to the array like any other job, and err_div_zero is tied 0.

## Structure
- Package div_sched_pkg holds:
  - LANES=16
  - the state enum (IDLE, LAUNCH, WAIT)
  - lane slicing helper constants.
- One sub-module, div_sched_sat: combinational per-lane saturation for the zero guard, instantiated only under DIV_SCHED_ZERO_GUARD_EN.
- The divider array is instantiated outside this block.

## Test plan
- Basic job: all lanes 1536 (12.0), divisor 3, array model with 10-cycle latency.
  - div_start at T+1.
  - out_valid at done+1.
  - every lane 512 (4.0).
- Backpressure: out_ready=0 for 30 cycles with a second job queued.
  - second div_start is withheld until out_ready=1.
  - first result is held unchanged.
  - in_ready=0 while the buffer is full.
- Timeout: model never raises div_done.
  - err_timeout=1 at TIMEOUT cycles after LAUNCH.
  - out_valid stays 0.
  - next job completes normally.
- Zero divisor, lanes {+640, -640, 0, …}, macro defined:
  - no div_start.
  - outputs 8191, -8192, 0.
  - err_div_zero=1.
- Same zero-divisor job with the macro undefined:
  - div_start issued.
  - err_div_zero stays 0.
- Reset asserted mid-WAIT:
  - all outputs at reset values in the same cycle.
  - first job after release behaves as in the basic-job case.
